// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Package     : addsub_pkg
// Description : Shared types and constants for the lab2 add/subtract
//               sequencer: FSM state encoding, operation select codes and
//               the default datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

  // Default operand/result width of the lab2 datapath
  localparam int DEF_W = 8;

  // Values driven on dp_sub
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    CAPT = 2'd3
  } state_t;

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser, stable-sample debounce counter and
//               rising-edge pulse for one raw push-button.
// Ports       : clk   in  system clock
//               rst   in  asynchronous active-high reset
//               btn   in  raw (asynchronous) button level
//               level out debounced button level
//               rise  out one-cycle pulse on the debounced rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // The counter tracks how many consecutive synchronised samples disagree
  // with the current debounced level; the level flips on the DB_CYCLES-th
  // such sample and any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
      rise <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync;
        rise  <= sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule : btn_debounce
`default_nettype wire

// File: rtl/addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : addsub_ctrl
// Description : Sequencer for the lab2 8-bit add/subtract datapath.
//               Debounces btnU/btnD, latches operands from sw, drives the
//               op select, waits DP_LAT cycles, captures result/overflow and
//               scans the 4-digit seven-segment anodes.
// Config      : ADDSUB_CTRL_ACCUM_EN - accumulator mode, operand A is taken
//               from the last result instead of sw[15:8].
// Ports       : clkin   in  system clock
//               btnR    in  asynchronous active-high reset
//               btnU    in  raw add request button
//               btnD    in  raw subtract request button
//               sw      in  sw[15:8] operand A, sw[7:0] operand B
//               dp_res  in  datapath result
//               dp_ovfl in  datapath signed overflow
//               dp_a    out operand A to datapath
//               dp_b    out operand B to datapath
//               dp_sub  out 0 = add, 1 = subtract
//               result  out last captured result
//               ovfl    out last captured overflow
//               busy    out high from LOAD through CAPT
//               done    out one-cycle pulse when result/ovfl update
//               digsel  out digit index being displayed (0 = rightmost)
//               an      out active-low one-hot anode select
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int DB_CYCLES = 16,
  parameter int DP_LAT    = 2,
  parameter int SCAN_BITS = 4
) (
  input  logic         clkin,
  input  logic         btnR,
  input  logic         btnU,
  input  logic         btnD,
  input  logic [15:0]  sw,
  input  logic [W-1:0] dp_res,
  input  logic         dp_ovfl,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  output logic         dp_sub,
  output logic [W-1:0] result,
  output logic         ovfl,
  output logic         busy,
  output logic         done,
  output logic [1:0]   digsel,
  output logic [3:0]   an
);

  localparam int LCW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [LCW-1:0] LAT_LAST = LCW'(DP_LAT - 1);

  logic           req_add;
  logic           req_sub;
  logic           lvl_add;
  logic           lvl_sub;
  state_t         state;
  state_t         state_nxt;
  logic           load_en;
  logic           capture;
  logic [LCW-1:0] lat_cnt;
  logic [W-1:0]   opa_src;
  logic [SCAN_BITS-1:0] scan;

  // --------------------------------------------------------------------------
  // Button conditioning
  // --------------------------------------------------------------------------
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_add (
    .clk   (clkin),
    .rst   (btnR),
    .btn   (btnU),
    .level (lvl_add),
    .rise  (req_add)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sub (
    .clk   (clkin),
    .rst   (btnR),
    .btn   (btnD),
    .level (lvl_sub),
    .rise  (req_sub)
  );

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clkin or posedge btnR) begin
    if (btnR) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (req_add || req_sub) begin
          load_en   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = EXEC;
      EXEC: begin
        if (lat_cnt == LAT_LAST) begin
          capture   = 1'b1;
          state_nxt = CAPT;
        end
      end
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Latency counter only advances inside EXEC, so it always starts from 0
  always_ff @(posedge clkin or posedge btnR) begin
    if (btnR) begin
      lat_cnt <= '0;
    end else if (state == EXEC) begin
      lat_cnt <= lat_cnt + 1'b1;
    end else begin
      lat_cnt <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Operand and result registers
  // --------------------------------------------------------------------------
`ifdef ADDSUB_CTRL_ACCUM_EN
  assign opa_src = result;
`else
  assign opa_src = W'(sw[15:8]);
`endif

  always_ff @(posedge clkin or posedge btnR) begin
    if (btnR) begin
      dp_a   <= '0;
      dp_b   <= '0;
      dp_sub <= OP_ADD;
    end else if (load_en) begin
      dp_a   <= opa_src;
      dp_b   <= W'(sw[7:0]);
      // add wins when both edges land in the same cycle
      dp_sub <= req_add ? OP_ADD : OP_SUB;
    end
  end

  // Capture happens on the edge into CAPT, so done and the new result
  // become visible in the same cycle.
  always_ff @(posedge clkin or posedge btnR) begin
    if (btnR) begin
      result <= '0;
      ovfl   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= capture;
      if (capture) begin
        result <= dp_res;
        ovfl   <= dp_ovfl;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Display scan
  // --------------------------------------------------------------------------
  always_ff @(posedge clkin or posedge btnR) begin
    if (btnR) begin
      scan <= '0;
    end else begin
      scan <= scan + 1'b1;
    end
  end

  assign digsel = scan[SCAN_BITS-1 -: 2];
  assign an     = ~(4'b0001 << digsel);

endmodule : addsub_ctrl
`default_nettype wire
